// File: rtl/pwm_adc_pkg.sv
// Shared types and helpers for the PWM reference ADC: FSM states, conversion
// mode encodings and counter sizing.
package pwm_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRIAL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic MODE_SWEEP = 1'b0;
    localparam logic MODE_SAR   = 1'b1;

    // Bits needed for a counter that spans 0 .. cycles-1 (never narrower than 1).
    function automatic int settle_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/pwm.sv
// Free-running PWM generator. Duty is only picked up at the period boundary,
// so a mid-period code change never produces a runt pulse.
module pwm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_duty,
    output logic             o_pwm
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_duty;

    // Parking the counter at its max while disabled makes the first enabled
    // cycle a period boundary, so the new duty is latched immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= CNT_MAX;
            r_duty <= '0;
        end else if (!i_enable) begin
            r_cnt  <= CNT_MAX;
            r_duty <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_MAX) begin
                r_duty <= i_duty;
            end
        end
    end

    assign o_pwm = i_enable && (r_cnt < r_duty);

endmodule

// File: rtl/pwm_adc_conv.sv
// PWM reference ADC: searches for the largest code whose filtered PWM level
// the comparator input still exceeds, by linear sweep or successive approximation.
module pwm_adc_conv
    import pwm_adc_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 10240
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             comp_result,
    output logic             compare_neg_pwm,
    output logic [WIDTH-1:0] duty_out,
    output logic             drdy_out,
    output logic [WIDTH-1:0] data_out,
    output logic             overrange
);

    localparam int CW = settle_cnt_width(SETTLE_CYCLES);
    localparam int BW = settle_cnt_width(WIDTH);

    localparam logic [WIDTH-1:0] CODE_MAX    = '1;
    localparam logic [WIDTH-1:0] SAR_START   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0]    BIT_MSB     = BW'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 12) begin : g_bad_width
            $error("pwm_adc_conv: WIDTH must be in 2..12");
        end
        if (SETTLE_CYCLES < 4) begin : g_bad_settle
            $error("pwm_adc_conv: SETTLE_CYCLES must be at least 4");
        end
    endgenerate

    state_t           r_state;
    logic             r_mode;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_result;
    logic             r_ovr_pend;
    logic [WIDTH-1:0] r_data;
    logic             r_ovr;
    logic             r_drdy;
    logic [CW-1:0]    r_settle;
    logic [BW-1:0]    r_bit;
    logic             r_sync1;
    logic             r_sync2;

    logic [WIDTH-1:0] w_start_duty;
    logic [WIDTH-1:0] w_sar_next;
    logic             w_pwm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= comp_result;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_start_duty = (mode == MODE_SAR) ? SAR_START : '0;
    end

    // SAR step: keep or drop the bit under test, then arm the next lower bit.
    always_comb begin
        w_sar_next = r_duty;
        if (!r_sync2) begin
            w_sar_next[r_bit] = 1'b0;
        end
        if (r_bit != '0) begin
            w_sar_next[r_bit - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_SWEEP;
            r_duty     <= '0;
            r_result   <= '0;
            r_ovr_pend <= 1'b0;
            r_data     <= '0;
            r_ovr      <= 1'b0;
            r_drdy     <= 1'b0;
            r_settle   <= '0;
            r_bit      <= '0;
        end else begin
            r_drdy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_settle <= '0;
                    if (enable) begin
                        r_mode  <= mode;
                        r_duty  <= w_start_duty;
                        r_bit   <= BIT_MSB;
                        r_state <= ST_TRIAL;
                    end else begin
                        r_duty <= '0;
                    end
                end

                ST_TRIAL: begin
                    if (!enable) begin
                        r_state  <= ST_IDLE;
                        r_duty   <= '0;
                        r_settle <= '0;
                    end else if (r_settle != SETTLE_LAST) begin
                        r_settle <= r_settle + 1'b1;
                    end else begin
                        r_settle <= '0;
                        if (r_mode == MODE_SAR) begin
                            r_duty <= w_sar_next;
                            if (r_bit == '0) begin
                                r_result   <= w_sar_next;
                                r_ovr_pend <= 1'b0;
                                r_state    <= ST_DONE;
                            end else begin
                                r_bit <= r_bit - 1'b1;
                            end
                        end else if (!r_sync2) begin
                            r_result   <= (r_duty == '0) ? '0 : r_duty - 1'b1;
                            r_ovr_pend <= 1'b0;
                            r_state    <= ST_DONE;
                        end else if (r_duty == CODE_MAX) begin
                            r_result   <= CODE_MAX;
                            r_ovr_pend <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_duty <= r_duty + 1'b1;
                        end
                    end
                end

                // Publish, then chain straight into the next conversion so
                // back-to-back results skip the IDLE cycle.
                ST_DONE: begin
                    r_drdy   <= 1'b1;
                    r_data   <= r_result;
                    r_ovr    <= r_ovr_pend;
                    r_settle <= '0;
                    if (enable) begin
                        r_mode  <= mode;
                        r_duty  <= w_start_duty;
                        r_bit   <= BIT_MSB;
                        r_state <= ST_TRIAL;
                    end else begin
                        r_duty  <= '0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_duty   <= '0;
                    r_settle <= '0;
                end
            endcase
        end
    end

    pwm #(
        .WIDTH (WIDTH)
    ) u_pwm (
        .clk      (clk),
        .reset    (reset),
        .i_enable (enable),
        .i_duty   (r_duty),
        .o_pwm    (w_pwm)
    );

    assign compare_neg_pwm = w_pwm;
    assign duty_out        = r_duty;
    assign drdy_out        = r_drdy;
    assign data_out        = r_data;
    assign overrange       = r_ovr;

endmodule

// File: tb/tb_pwm_adc_conv.sv
// Self-checking bench for pwm_adc_conv: an ideal comparator (vin >= duty code)
// closes the loop, and results are predicted from plain arithmetic on vin.
module tb_pwm_adc_conv;

    localparam int W    = 4;
    localparam int S    = 8;
    localparam int MAXC = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         mode;
    logic         comp_result;
    logic         compare_neg_pwm;
    logic [W-1:0] duty_out;
    logic         drdy_out;
    logic [W-1:0] data_out;
    logic         overrange;

    int vin;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign comp_result = (vin >= int'(duty_out));

    pwm_adc_conv #(
        .WIDTH         (W),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .mode            (mode),
        .comp_result     (comp_result),
        .compare_neg_pwm (compare_neg_pwm),
        .duty_out        (duty_out),
        .drdy_out        (drdy_out),
        .data_out        (data_out),
        .overrange       (overrange)
    );

    // Largest code c in 0..MAXC with vin >= c (0 if none qualifies).
    function automatic int model_code(input int v);
        if (v < 0) return 0;
        if (v > MAXC) return MAXC;
        return v;
    endfunction

    function automatic bit model_sweep_ovr(input int v);
        return v >= MAXC;
    endfunction

    // Sweep tries codes 0,1,2,... until the comparator first reads 0 or max is accepted.
    function automatic int model_sweep_latency(input int v);
        int trials;
        if (v < 0) trials = 1;
        else if (v >= MAXC) trials = MAXC + 1;
        else trials = v + 2;
        return trials * S + 2;
    endfunction

    // Code presented on trial j of a textbook binary search for v.
    function automatic int model_sar_trial(input int v, input int j);
        int acc;
        int t;
        acc = 0;
        for (int k = 0; k < j; k++) begin
            t = acc | (1 << (W - 1 - k));
            if (v >= t) acc = t;
        end
        return acc | (1 << (W - 1 - j));
    endfunction

    task automatic wait_drdy(input int limit, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            if (drdy_out) seen = 1'b1;
        end
    endtask

    task automatic start_conv(input int v, input logic m);
        @(negedge clk);
        vin    = v;
        mode   = m;
        enable = 1'b1;
    endtask

    task automatic stop_conv();
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        mode   = 1'b0;
        vin    = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({drdy_out, data_out, overrange, duty_out, compare_neg_pwm} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got drdy=%0b data=%0d ovr=%0b duty=%0d pwm=%0b expected all 0",
                     drdy_out, data_out, overrange, duty_out, compare_neg_pwm);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_sweep();
        int  v;
        int  cyc;
        bit  seen;
        for (int t = 0; t < 7; t++) begin
            v = (t == 0) ? 5 : (t == 1) ? 15 : (t == 2) ? -1 : int'($urandom_range(0, 14));
            start_conv(v, 1'b0);
            wait_drdy(400, cyc, seen);
            checks++;
            if (!seen || cyc != model_sweep_latency(v)) begin
                errors++;
                $display("[TB] FAIL sweep_latency vin=%0d: got %0d cycles (seen=%0b) expected %0d",
                         v, cyc, seen, model_sweep_latency(v));
            end
            checks++;
            if (int'(data_out) != model_code(v)) begin
                errors++;
                $display("[TB] FAIL sweep_data vin=%0d: got %0d expected %0d", v, data_out, model_code(v));
            end
            checks++;
            if (overrange !== model_sweep_ovr(v)) begin
                errors++;
                $display("[TB] FAIL sweep_ovr vin=%0d: got %0b expected %0b", v, overrange, model_sweep_ovr(v));
            end
            stop_conv();
        end
    endtask

    task automatic test_sar();
        int v;
        int cyc;
        for (int t = 0; t < 6; t++) begin
            v = (t == 0) ? 11 : (t == 1) ? 0 : int'($urandom_range(0, 15));
            start_conv(v, 1'b1);
            cyc = 0;
            while (cyc < 200) begin
                @(posedge clk);
                #1;
                cyc++;
                if ((cyc - 1) % S == 0 && (cyc - 1) / S < W) begin
                    checks++;
                    if (int'(duty_out) != model_sar_trial(v, (cyc - 1) / S)) begin
                        errors++;
                        $display("[TB] FAIL sar_trial vin=%0d j=%0d: got %0d expected %0d",
                                 v, (cyc - 1) / S, duty_out, model_sar_trial(v, (cyc - 1) / S));
                    end
                end
                if (drdy_out) break;
            end
            checks++;
            if (cyc != W * S + 2) begin
                errors++;
                $display("[TB] FAIL sar_latency vin=%0d: got %0d expected %0d", v, cyc, W * S + 2);
            end
            checks++;
            if (int'(data_out) != model_code(v) || overrange !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sar_data vin=%0d: got %0d ovr=%0b expected %0d ovr=0",
                         v, data_out, overrange, model_code(v));
            end
            stop_conv();
        end
    endtask

    task automatic test_mode_switch();
        int cyc;
        int cyc2;
        bit seen;
        start_conv(5, 1'b0);
        wait_drdy(200, cyc, seen);
        checks++;
        if (!seen || cyc != model_sweep_latency(5) || int'(data_out) != 5) begin
            errors++;
            $display("[TB] FAIL mode_first: got cyc=%0d data=%0d expected cyc=%0d data=5",
                     cyc, data_out, model_sweep_latency(5));
        end
        repeat (20) @(posedge clk);
        #1;
        mode = 1'b1;
        wait_drdy(200, cyc2, seen);
        cyc2 += 20;
        checks++;
        if (!seen || cyc2 != model_sweep_latency(5) - 1 || int'(data_out) != 5) begin
            errors++;
            $display("[TB] FAIL mode_second_sweep: got gap=%0d data=%0d expected gap=%0d data=5",
                     cyc2, data_out, model_sweep_latency(5) - 1);
        end
        wait_drdy(200, cyc, seen);
        checks++;
        if (!seen || cyc != W * S + 1 || int'(data_out) != 5) begin
            errors++;
            $display("[TB] FAIL mode_third_sar: got gap=%0d data=%0d expected gap=%0d data=5",
                     cyc, data_out, W * S + 1);
        end
        stop_conv();
    endtask

    task automatic test_abort();
        bit seen;
        int prior;
        prior = int'(data_out);
        seen  = 1'b0;
        start_conv(11, 1'b1);
        repeat (20) begin
            @(posedge clk);
            #1;
            if (drdy_out) seen = 1'b1;
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (duty_out !== '0 || compare_neg_pwm !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_duty: got duty=%0d pwm=%0b expected 0/0", duty_out, compare_neg_pwm);
        end
        repeat (50) begin
            @(posedge clk);
            #1;
            if (drdy_out) seen = 1'b1;
        end
        checks++;
        if (seen || int'(data_out) != prior || overrange !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_hold: got drdy_seen=%0b data=%0d ovr=%0b expected 0/%0d/0",
                     seen, data_out, overrange, prior);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        start_conv(15, 1'b0);
        wait_drdy(400, cyc, seen);
        checks++;
        if (!seen || int'(data_out) != MAXC || overrange !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_ovr: got data=%0d ovr=%0b expected %0d/1", data_out, overrange, MAXC);
        end
        mode = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({drdy_out, data_out, overrange, duty_out} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got drdy=%0b data=%0d ovr=%0b duty=%0d expected all 0",
                     drdy_out, data_out, overrange, duty_out);
        end
        enable = 1'b0;
        reset  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int v;
        bit seen;
        v = int'($urandom_range(0, 15));
        start_conv(v, 1'b1);
        wait_drdy(200, cyc, seen);
        checks++;
        if (!seen || cyc != W * S + 2 || int'(data_out) != model_code(v)) begin
            errors++;
            $display("[TB] FAIL b2b_first vin=%0d: got cyc=%0d data=%0d expected cyc=%0d data=%0d",
                     v, cyc, data_out, W * S + 2, model_code(v));
        end
        for (int n = 0; n < 3; n++) begin
            v   = int'($urandom_range(0, 15));
            vin = v;
            wait_drdy(200, cyc, seen);
            checks++;
            if (!seen || cyc != W * S + 1 || int'(data_out) != model_code(v)) begin
                errors++;
                $display("[TB] FAIL b2b_gap n=%0d vin=%0d: got gap=%0d data=%0d expected gap=%0d data=%0d",
                         n, v, cyc, data_out, W * S + 1, model_code(v));
            end
        end
        stop_conv();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_sweep();
        test_sar();
        test_mode_switch();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
